// File: rtl/incline_pkg.sv
// Shared types for the incline saturation filter: FSM state encoding and
// the signed saturation limits for a given output width.
package incline_pkg;

   typedef enum logic {
      UNPRIMED = 1'b0,
      RUN      = 1'b1
   } state_t;

   typedef struct packed {
      int lo;
      int hi;
   } sat_lim_t;

   function automatic sat_lim_t sat_limits(input int unsigned out_w);
      sat_lim_t lim;
      lim.hi = (1 << (out_w - 1)) - 1;
      lim.lo = -(1 << (out_w - 1));
      return lim;
   endfunction

endpackage

// File: rtl/incline_sat_filt_clamp.sv
// sat_clamp: combinational signed clamp from IN_W down to the OUT_W range,
// with a flag raised whenever the value had to be clipped.
module sat_clamp
   import incline_pkg::*;
#(
   parameter int IN_W  = 13,
   parameter int OUT_W = 10
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    clipped
);

   localparam sat_lim_t LIM = sat_limits(OUT_W);
   localparam logic signed [IN_W-1:0] HI = IN_W'(LIM.hi);
   localparam logic signed [IN_W-1:0] LO = IN_W'(LIM.lo);

   always_comb begin
      clipped = 1'b0;
      dout    = din[OUT_W-1:0];
      if (din > HI) begin
         dout    = HI[OUT_W-1:0];
         clipped = 1'b1;
      end else if (din < LO) begin
         dout    = LO[OUT_W-1:0];
         clipped = 1'b1;
      end
   end

endmodule

// File: rtl/incline_sat_filt.sv
// Two-stage incline conditioner: clamp to OUT_W, then EMA filter and register.
// Define INCLINE_SLEW_LIMIT_EN to add a per-sample slew limit of SLEW_MAX.
module incline_sat_filt
   import incline_pkg::*;
#(
   parameter int IN_W     = 13,
   parameter int OUT_W    = 10,
   parameter int AVG_LOG2 = 2,
   parameter int SLEW_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   input  logic [IN_W-1:0]  incline,
   input  logic             clr_cnt,
   output logic             out_vld,
   output logic [OUT_W-1:0] incline_sat,
   output logic             sat_flag,
   output logic [7:0]       sat_cnt
);

   localparam int AW = OUT_W + AVG_LOG2;
   localparam bit CFG_OK = (OUT_W < IN_W) && (AVG_LOG2 >= 0) && (AVG_LOG2 <= 4) && (SLEW_MAX > 0);

   // Empty marker block: present only for an illegal parameter set.
   if (!CFG_OK) begin : g_cfg_illegal_parameters
   end

   state_t                  state;
   logic                    s1_vld;
   logic                    s1_clip;
   logic signed [OUT_W-1:0] s1_val;
   logic signed [OUT_W-1:0] clamp_val;
   logic                    clamp_clip;
   logic signed [AW-1:0]    acc;
   logic signed [AW:0]      acc_sum;
   logic signed [AW-1:0]    acc_nxt;
   logic signed [AW-1:0]    acc_prime;
   logic signed [OUT_W-1:0] filt;
   logic signed [OUT_W-1:0] sat_nxt;

   sat_clamp #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_clamp (
      .din     (incline),
      .dout    (clamp_val),
      .clipped (clamp_clip)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_clip <= 1'b0;
         s1_val  <= '0;
      end else begin
         s1_vld <= in_vld;
         if (in_vld) begin
            s1_val  <= clamp_val;
            s1_clip <= clamp_clip;
         end
      end
   end

   // One guard bit keeps acc + s transiently representable before the subtract.
   always_comb begin
      acc_sum   = (AW+1)'(acc) + (AW+1)'(s1_val) - (AW+1)'(acc >>> AVG_LOG2);
      acc_nxt   = acc_sum[AW-1:0];
      acc_prime = AW'(s1_val) <<< AVG_LOG2;
      filt      = OUT_W'(acc_nxt >>> AVG_LOG2);
   end

`ifdef INCLINE_SLEW_LIMIT_EN
   localparam logic signed [OUT_W:0] SLEW_LIM = (OUT_W+1)'(SLEW_MAX);

   logic signed [OUT_W:0] diff;
   logic signed [OUT_W:0] step;
   logic signed [OUT_W:0] slewed;

   // Result lies between prev and filt, so truncating back to OUT_W is exact.
   always_comb begin
      diff = (OUT_W+1)'(filt) - (OUT_W+1)'($signed(incline_sat));
      step = diff;
      if (diff > SLEW_MAX) begin
         step = SLEW_LIM;
      end else if (diff < -SLEW_MAX) begin
         step = -SLEW_LIM;
      end
      slewed  = (OUT_W+1)'($signed(incline_sat)) + step;
      sat_nxt = slewed[OUT_W-1:0];
   end
`else
   always_comb begin
      sat_nxt = filt;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= UNPRIMED;
         acc         <= '0;
         incline_sat <= '0;
         out_vld     <= 1'b0;
         sat_flag    <= 1'b0;
         sat_cnt     <= '0;
      end else begin
         out_vld <= s1_vld;
         if (clr_cnt) begin
            sat_cnt <= '0;
         end else if (s1_vld && s1_clip && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 8'd1;
         end
         if (s1_vld) begin
            sat_flag <= s1_clip;
            if (state == UNPRIMED) begin
               acc         <= acc_prime;
               incline_sat <= s1_val;
               state       <= RUN;
            end else begin
               acc         <= acc_nxt;
               incline_sat <= sat_nxt;
            end
         end
      end
   end

endmodule
